wwm_btn_debouncer: RTL and testbench

Per-button synchronizer, debouncer and pulse generator for the World War Math front panel. It sits between the raw Nexys4 push-buttons and the game state machine, and turns bouncing asynchronous levels into clean, single-cycle enables. Bit 0 of `btn_scen` drives Start (BtnU) and bit 1 drives Fire/Ack (BtnR), so one press produces exactly one state-machine event.

---
 rtl/wwm_pkg.sv | 55 +++++
 rtl/wwm_btn_debouncer_if.sv | 14 +
 rtl/wwm_debounce_fsm.sv | 121 ++++++++++++
 rtl/wwm_btn_debouncer.sv | 42 ++++
 tb/tb_wwm_btn_debouncer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wwm_pkg.sv
// Shared types and constants for the front-panel button debouncer.
// Holds the per-channel FSM state encoding, the output bundle decoded
// from a state, and the default / short simulation timing constants.
package wwm_pkg;

    typedef enum logic [2:0] {
        ST_INI  = 3'd0,
        ST_WQ   = 3'd1,
        ST_SCEN = 3'd2,
        ST_MCW  = 3'd3,
        ST_MCEN = 3'd4,
        ST_WFCR = 3'd5
    } btn_state_t;

    typedef struct packed {
        logic db;
        logic scen;
        logic mcen;
    } btn_out_t;

    // 25 ms / 100 ms at 100 MHz on the board
    localparam int DEBOUNCE_CNT_DEF = 2_500_000;
    localparam int REPEAT_CNT_DEF   = 10_000_000;
    localparam int CNT_W_DEF        = 24;

    // Short windows so simulation reaches every state in a few cycles
    localparam int SIM_DEBOUNCE_CNT = 4;
    localparam int SIM_REPEAT_CNT   = 8;

    // Output levels belonging to a state; the FSM registers these
    // together with the state so outputs never depend on btn_in directly.
    function automatic btn_out_t f_decode_out(input btn_state_t st);
        btn_out_t v;
        v = btn_out_t'(3'b000);
        case (st)
            ST_SCEN: begin
                v.db   = 1'b1;
                v.scen = 1'b1;
                v.mcen = 1'b1;
            end
            ST_MCEN: begin
                v.db   = 1'b1;
                v.mcen = 1'b1;
            end
            ST_MCW, ST_WFCR: begin
                v.db   = 1'b1;
            end
            default: begin
                v = btn_out_t'(3'b000);
            end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/wwm_btn_debouncer_if.sv
// Button bus between the raw panel and the game state machine.
// master drives the raw levels, slave (the debouncer) returns the
// debounced level and the single / multiple clock enables.
interface wwm_btn_debouncer_if #(
    parameter int N_BTNS = 2
);
    logic [N_BTNS-1:0] btn_in;
    logic [N_BTNS-1:0] btn_db;
    logic [N_BTNS-1:0] btn_scen;
    logic [N_BTNS-1:0] btn_mcen;

    modport master (output btn_in, input btn_db, input btn_scen, input btn_mcen);
    modport slave  (input btn_in, output btn_db, output btn_scen, output btn_mcen);
endinterface

// File: rtl/wwm_debounce_fsm.sv
// One button channel: 2-flop synchronizer, shared timing counter and a
// Moore FSM that qualifies presses, issues the single-cycle enable and
// the auto-repeat enables, and waits for a clean release.
module wwm_debounce_fsm
    import wwm_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int REPEAT_CNT   = REPEAT_CNT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic i_btn,
    output logic o_db,
    output logic o_scen,
    output logic o_mcen
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s0;
    logic             r_s1;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    btn_out_t         r_out;

    // Bring the asynchronous button level into the board_clk domain
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= i_btn;
            r_s1 <= r_s0;
        end
    end

    // Channel FSM; outputs are registered alongside every state change
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_INI;
            r_cnt   <= CNT_ZERO;
            r_out   <= f_decode_out(ST_INI);
        end else begin
            case (r_state)
                ST_INI: begin
                    r_cnt <= CNT_ZERO;
                    if (r_s1) begin
                        r_state <= ST_WQ;
                        r_out   <= f_decode_out(ST_WQ);
                    end else begin
                        r_state <= ST_INI;
                    end
                end
                ST_WQ: begin
                    if (!r_s1) begin
                        r_state <= ST_INI;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= f_decode_out(ST_INI);
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= ST_SCEN;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= f_decode_out(ST_SCEN);
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_SCEN: begin
                    r_state <= ST_MCW;
                    r_cnt   <= CNT_ZERO;
                    r_out   <= f_decode_out(ST_MCW);
                end
                ST_MCW: begin
                    if (!r_s1) begin
                        r_state <= ST_WFCR;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= f_decode_out(ST_WFCR);
                    end else if (r_cnt == RPT_LAST) begin
                        r_state <= ST_MCEN;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= f_decode_out(ST_MCEN);
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_MCEN: begin
                    r_state <= ST_MCW;
                    r_cnt   <= CNT_ZERO;
                    r_out   <= f_decode_out(ST_MCW);
                end
                ST_WFCR: begin
                    // a bounce during release goes back to holding, never to a new press
                    if (r_s1) begin
                        r_state <= ST_MCW;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= f_decode_out(ST_MCW);
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= ST_INI;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= f_decode_out(ST_INI);
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_INI;
                    r_cnt   <= CNT_ZERO;
                    r_out   <= f_decode_out(ST_INI);
                end
            endcase
        end
    end

    assign o_db   = r_out.db;
    assign o_scen = r_out.scen;
    assign o_mcen = r_out.mcen;

endmodule

// File: rtl/wwm_btn_debouncer.sv
// Front-panel debouncer: N_BTNS fully independent channels between the
// raw Nexys4 push-buttons and the game state machine.
module wwm_btn_debouncer
    import wwm_pkg::*;
#(
    parameter int N_BTNS       = 2,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int REPEAT_CNT   = REPEAT_CNT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                 board_clk,
    input  logic                 Reset,
    wwm_btn_debouncer_if.slave   btn_bus
);

    logic [N_BTNS-1:0] w_db;
    logic [N_BTNS-1:0] w_scen;
    logic [N_BTNS-1:0] w_mcen;

    genvar g;
    generate
        for (g = 0; g < N_BTNS; g = g + 1) begin : g_ch
            wwm_debounce_fsm #(
                .DEBOUNCE_CNT (DEBOUNCE_CNT),
                .REPEAT_CNT   (REPEAT_CNT),
                .CNT_W        (CNT_W)
            ) u_fsm (
                .board_clk (board_clk),
                .Reset     (Reset),
                .i_btn     (btn_bus.btn_in[g]),
                .o_db      (w_db[g]),
                .o_scen    (w_scen[g]),
                .o_mcen    (w_mcen[g])
            );
        end
    endgenerate

    assign btn_bus.btn_db   = w_db;
    assign btn_bus.btn_scen = w_scen;
    assign btn_bus.btn_mcen = w_mcen;

endmodule

// File: tb/tb_wwm_btn_debouncer.sv
// Bench for wwm_btn_debouncer: directed scenarios plus random button
// activity, all compared every cycle against a behavioural model built
// from run lengths of the synchronized level and event timestamps.
module tb_wwm_btn_debouncer;
    import wwm_pkg::*;

    localparam int NB = 2;
    localparam int D  = SIM_DEBOUNCE_CNT;
    localparam int R  = SIM_REPEAT_CNT;
    localparam int PH_IDLE = 0;
    localparam int PH_HELD = 1;
    localparam int PH_REL  = 2;

    logic board_clk;
    logic Reset;

    wwm_btn_debouncer_if #(.N_BTNS(NB)) bus ();

    wwm_btn_debouncer #(
        .N_BTNS(NB), .DEBOUNCE_CNT(D), .REPEAT_CNT(R), .CNT_W(CNT_W_DEF)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .btn_bus   (bus)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, $signed(obs), $signed(exp));
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]    m_hist[$];
    int            m_n;
    int            m_phase[NB];
    int            m_hi[NB];
    int            m_anchor[NB];
    int            m_rel[NB];
    logic [NB-1:0] m_db, m_scen, m_mcen;

    task automatic model_reset();
        m_hist.delete();
        m_n    = 0;
        m_db   = 2'b00;
        m_scen = 2'b00;
        m_mcen = 2'b00;
        for (int c = 0; c < NB; c++) begin
            m_phase[c]  = PH_IDLE;
            m_hi[c]     = 0;
            m_anchor[c] = 0;
            m_rel[c]    = 0;
        end
    endtask

    // One clock edge: the level seen by the channel logic is the input two edges ago.
    task automatic model_step();
        logic [1:0] s_vec;
        logic       s;
        s_vec = (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 2'b00;
        m_hist.push_back(bus.btn_in);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        for (int c = 0; c < NB; c++) begin
            s = s_vec[c];
            m_scen[c] = 1'b0;
            m_mcen[c] = 1'b0;
            case (m_phase[c])
                PH_IDLE: begin
                    m_hi[c] = s ? m_hi[c] + 1 : 0;
                    if (m_hi[c] == D + 1) begin
                        m_phase[c]  = PH_HELD;
                        m_db[c]     = 1'b1;
                        m_scen[c]   = 1'b1;
                        m_mcen[c]   = 1'b1;
                        m_anchor[c] = m_n + 1;
                    end
                end
                PH_HELD: begin
                    if (m_n > m_anchor[c]) begin
                        if (!s) begin
                            m_phase[c] = PH_REL;
                            m_rel[c]   = m_n;
                        end else if (m_n == m_anchor[c] + R) begin
                            m_mcen[c]   = 1'b1;
                            m_anchor[c] = m_n + 1;
                        end
                    end
                end
                PH_REL: begin
                    if (s) begin
                        m_phase[c]  = PH_HELD;
                        m_anchor[c] = m_n;
                    end else if (m_n - m_rel[c] == D) begin
                        m_phase[c] = PH_IDLE;
                        m_db[c]    = 1'b0;
                        m_hi[c]    = 0;
                    end
                end
                default: ;
            endcase
        end
        m_n++;
    endtask

    // ---------------- per-scenario observations ----------------
    int            cyc = 0;
    int            base = 0;
    int            scen_cnt[NB], scen_first[NB], db_rise[NB], db_fall[NB], db_hi[NB];
    int            mcen_at[NB][$];
    logic          any_out;
    logic [NB-1:0] prev_db;

    task automatic clear_stats();
        base = cyc;
        for (int c = 0; c < NB; c++) begin
            scen_cnt[c] = 0; scen_first[c] = -1;
            db_rise[c] = -1; db_fall[c] = -1; db_hi[c] = 0;
            mcen_at[c].delete();
        end
        any_out = 1'b0;
        prev_db = bus.btn_db;
    endtask

    task automatic tick();
        int e;
        @(posedge board_clk);
        model_step();
        e = cyc - base;
        cyc++;
        @(negedge board_clk);
        chk("db",   32'(bus.btn_db),   32'(m_db));
        chk("scen", 32'(bus.btn_scen), 32'(m_scen));
        chk("mcen", 32'(bus.btn_mcen), 32'(m_mcen));
        for (int c = 0; c < NB; c++) begin
            if (bus.btn_scen[c]) begin
                scen_cnt[c]++;
                if (scen_first[c] < 0) scen_first[c] = e;
            end
            if (bus.btn_mcen[c]) mcen_at[c].push_back(e);
            if (bus.btn_db[c] && !prev_db[c] && db_rise[c] < 0) db_rise[c] = e;
            if (!bus.btn_db[c] && prev_db[c]) db_fall[c] = e;
            if (bus.btn_db[c]) db_hi[c]++;
        end
        any_out = any_out | (|(bus.btn_db | bus.btn_scen | bus.btn_mcen));
        prev_db = bus.btn_db;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called just after a compare (negedge); the skipped posedge happens under reset.
    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #1;
        chk("rst_out", 32'({bus.btn_db, bus.btn_scen, bus.btn_mcen}), 32'd0);
        @(negedge board_clk);
        Reset = 1'b0;
    endtask

    function automatic int q_at(input int c, input int k);
        return (mcen_at[c].size() > k) ? mcen_at[c][k] : -1;
    endfunction

    initial begin
        int n;
        Reset      = 1'b1;
        bus.btn_in = 2'b00;
        model_reset();
        #1;
        chk("rst_state", 32'({bus.btn_db, bus.btn_scen, bus.btn_mcen}), 32'd0);
        @(negedge board_clk);
        Reset = 1'b0;

        // 1. clean press, then 4. release glitch on the same press
        clear_stats();
        bus.btn_in = 2'b01;
        ticks(20);
        chk("s1_scen_edge", 32'(scen_first[0]), 32'd6);
        chk("s1_scen_cnt",  32'(scen_cnt[0]),   32'd1);
        chk("s1_db_rise",   32'(db_rise[0]),    32'd6);
        chk("s1_ch1_quiet", 32'(db_hi[1] + scen_cnt[1] + mcen_at[1].size()), 32'd0);
        clear_stats();
        bus.btn_in = 2'b00; ticks(2);
        bus.btn_in = 2'b01; ticks(1);
        bus.btn_in = 2'b00; ticks(12);
        chk("s4_no_scen", 32'(scen_cnt[0]), 32'd0);
        chk("s4_db_fall", 32'(db_fall[0]),  32'd9);

        // 2. bounce shorter than the debounce window
        do_reset();
        clear_stats();
        bus.btn_in = 2'b01; ticks(3);
        bus.btn_in = 2'b00; ticks(1);
        bus.btn_in = 2'b01; ticks(2);
        bus.btn_in = 2'b00; ticks(10);
        chk("s2_quiet", 32'(any_out), 32'd0);

        // 3. hold and auto-repeat on channel 1
        do_reset();
        clear_stats();
        bus.btn_in = 2'b10;
        ticks(40);
        chk("s3_scen_cnt", 32'(scen_cnt[1]), 32'd1);
        chk("s3_mcen_n",   32'(mcen_at[1].size()), 32'd4);
        chk("s3_mcen0",    32'(q_at(1, 0)), 32'd6);
        chk("s3_mcen1",    32'(q_at(1, 1)), 32'd15);
        chk("s3_mcen2",    32'(q_at(1, 2)), 32'd24);
        chk("s3_db_hold",  32'(db_hi[1]), 32'd34);
        bus.btn_in = 2'b00;
        ticks(10);

        // 5. reset while held
        do_reset();
        clear_stats();
        bus.btn_in = 2'b01;
        ticks(12);
        chk("s5_db_pre", 32'(bus.btn_db[0]), 32'd1);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("s5_async_zero", 32'({bus.btn_db, bus.btn_scen, bus.btn_mcen}), 32'd0);
        @(negedge board_clk);
        Reset = 1'b0;
        clear_stats();
        ticks(10);
        chk("s5_scen_edge", 32'(scen_first[0]), 32'd6);
        chk("s5_scen_cnt",  32'(scen_cnt[0]),   32'd1);

        // 6. simultaneous press
        bus.btn_in = 2'b00;
        do_reset();
        clear_stats();
        bus.btn_in = 2'b11;
        ticks(12);
        chk("s6_scen0", 32'(scen_first[0]), 32'd6);
        chk("s6_scen1", 32'(scen_first[1]), 32'd6);
        bus.btn_in = 2'b00;
        ticks(10);

        // random activity: short bounces, long holds, occasional reset
        for (int seg = 0; seg < 300; seg++) begin
            bus.btn_in = 2'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
            ticks(n);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
